// File: rtl/alu_seq_if.sv
// alu_seq_if -- request/response bundle for the sequential ALU.
//
// Carries the request handshake (in_valid/in_ready) with operands A, B and
// opcode sel, and the response handshake (out_valid/out_ready) with the
// registered result and its flags (carry, ovf, zero, neg).
//   master : request producer / result consumer (drives in_valid, A, B, sel,
//            out_ready)
//   slave  : the ALU (drives in_ready, out_valid, result and flags)
// WIDTH must match the WIDTH of the alu_seq instance it connects to.
interface alu_seq_if #(
  parameter int WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             ovf;
  logic             zero;
  logic             neg;

  modport master (
    output in_valid, A, B, sel, out_ready,
    input  in_ready, out_valid, result, carry, ovf, zero, neg
  );

  modport slave (
    input  in_valid, A, B, sel, out_ready,
    output in_ready, out_valid, result, carry, ovf, zero, neg
  );

endinterface

// File: rtl/alu_seq.sv
// alu_seq -- sequential ALU with valid/ready handshakes on both sides.
//
// One operation is in flight at a time. Single-cycle ops (ADD, SUB, AND, OR,
// NOT, XOR, reserved) go IDLE -> HOLD on the accepting edge. With the
// ALU_SEQ_MUL_EN macro defined, MUL (sel 110) goes IDLE -> CALC, runs an
// unsigned shift-add for WIDTH cycles on operands latched at accept, then
// enters HOLD. Without ALU_SEQ_MUL_EN there is no CALC state and no
// multiplier; sel 110 behaves as the reserved opcode 111.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (aborts any op in flight)
//   bus    alu_seq_if.slave: in_valid/in_ready, A, B, sel,
//          out_valid/out_ready, result, carry, ovf, zero, neg
//
// All outputs are registered. WIDTH legal range is 4..32.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;

`ifdef ALU_SEQ_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam int         CW     = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd2
  } state_t;
`endif

  state_t             state_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [WIDTH-1:0]   result_r;
  logic               carry_r;
  logic               ovf_r;
  logic               zero_r;
  logic               neg_r;

  logic [WIDTH:0]     sum_s;
  logic [WIDTH:0]     diff_s;
  logic [WIDTH-1:0]   alu_res_s;
  logic               alu_carry_s;
  logic               alu_ovf_s;

`ifdef ALU_SEQ_MUL_EN
  // Multiplicand is pre-widened so it can be shifted left into the high half.
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [CW-1:0]      count_r;
  logic [2*WIDTH-1:0] acc_next_s;
`endif

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.carry     = carry_r;
  assign bus.ovf       = ovf_r;
  assign bus.zero      = zero_r;
  assign bus.neg       = neg_r;

  // Single-cycle datapath for every opcode except the sequential multiply.
  always_comb begin
    sum_s       = {1'b0, bus.A} + {1'b0, bus.B};
    // Bit WIDTH of the extended difference is the unsigned borrow (A < B).
    diff_s      = {1'b0, bus.A} - {1'b0, bus.B};
    alu_res_s   = {WIDTH{1'b0}};
    alu_carry_s = 1'b0;
    alu_ovf_s   = 1'b0;
    case (bus.sel)
      OP_ADD: begin
        alu_res_s   = sum_s[WIDTH-1:0];
        alu_carry_s = sum_s[WIDTH];
        alu_ovf_s   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                      (sum_s[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_s   = diff_s[WIDTH-1:0];
        alu_carry_s = diff_s[WIDTH];
        alu_ovf_s   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                      (diff_s[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_AND: begin
        alu_res_s = bus.A & bus.B;
      end
      OP_OR: begin
        alu_res_s = bus.A | bus.B;
      end
      OP_NOT: begin
        alu_res_s = ~bus.A;
      end
      OP_XOR: begin
        alu_res_s = bus.A ^ bus.B;
      end
      default: begin
        // Reserved opcode (and MUL when the multiplier is not built).
        alu_res_s   = {WIDTH{1'b0}};
        alu_carry_s = 1'b0;
        alu_ovf_s   = 1'b0;
      end
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  // Partial-product accumulate for the current multiplier LSB.
  always_comb begin
    if (mplier_r[0]) begin
      acc_next_s = acc_r + mcand_r;
    end else begin
      acc_next_s = acc_r;
    end
  end
`endif

  // Control FSM with registered handshake outputs, result and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      ovf_r       <= 1'b0;
      zero_r      <= 1'b1;
      neg_r       <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mcand_r     <= {(2*WIDTH){1'b0}};
      mplier_r    <= {WIDTH{1'b0}};
      acc_r       <= {(2*WIDTH){1'b0}};
      count_r     <= {CW{1'b0}};
`endif
    end else begin
      case (state_r)
        IDLE: begin
          // in_ready is high only here, so this is the accept condition.
          if (bus.in_valid) begin
            in_ready_r <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            if (bus.sel == OP_MUL) begin
              mcand_r  <= {{WIDTH{1'b0}}, bus.A};
              mplier_r <= bus.B;
              acc_r    <= {(2*WIDTH){1'b0}};
              count_r  <= {CW{1'b0}};
              state_r  <= CALC;
            end else
`endif
            begin
              result_r    <= alu_res_s;
              carry_r     <= alu_carry_s;
              ovf_r       <= alu_ovf_s;
              zero_r      <= (alu_res_s == {WIDTH{1'b0}});
              neg_r       <= alu_res_s[WIDTH-1];
              out_valid_r <= 1'b1;
              state_r     <= HOLD;
            end
          end
        end
`ifdef ALU_SEQ_MUL_EN
        CALC: begin
          acc_r    <= acc_next_s;
          mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
          count_r  <= count_r + 1'b1;
          // The final step publishes the accumulated value directly so the
          // result lands on the WIDTH-th CALC edge.
          if (count_r == LAST_STEP) begin
            result_r    <= acc_next_s[WIDTH-1:0];
            carry_r     <= |acc_next_s[2*WIDTH-1:WIDTH];
            ovf_r       <= 1'b0;
            zero_r      <= (acc_next_s[WIDTH-1:0] == {WIDTH{1'b0}});
            neg_r       <= acc_next_s[WIDTH-1];
            out_valid_r <= 1'b1;
            state_r     <= HOLD;
          end
        end
`endif
        HOLD: begin
          // Retire; in_ready returns next cycle, never in the retire cycle.
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq -- directed self-checking bench for alu_seq.
// Drives a WIDTH=8 instance through the opcode table, hold/backpressure,
// multiply latency and reset abort, plus a WIDTH=4 instance for the narrow
// ADD overflow case. Multiply expectations follow ALU_SEQ_MUL_EN.
module tb_alu_seq;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  alu_seq_if #(.WIDTH(8)) bus8 ();
  alu_seq_if #(.WIDTH(4)) bus4 ();

  alu_seq #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  alu_seq #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [2:0] sel;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       c;
    logic       o;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one request on the 8-bit bus, scramble inputs after accept and
  // return the number of edges (accept edge = 1) until out_valid is seen.
  task automatic issue8(input logic [2:0] s, input logic [7:0] a,
                        input logic [7:0] b, output int lat);
    bus8.sel      = s;
    bus8.A        = a;
    bus8.B        = b;
    bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    bus8.A        = ~a;
    bus8.B        = ~b;
    bus8.sel      = 3'b010;
    lat = 1;
    while (bus8.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_reset8(input string p);
    check({p, "_out_valid"}, 32'(bus8.out_valid), 32'd0);
    check({p, "_result"},    32'(bus8.result),    32'd0);
    check({p, "_carry"},     32'(bus8.carry),     32'd0);
    check({p, "_ovf"},       32'(bus8.ovf),       32'd0);
    check({p, "_neg"},       32'(bus8.neg),       32'd0);
    check({p, "_zero"},      32'(bus8.zero),      32'd1);
  endtask

  initial begin
    int  lat;
    bit  seen;

    n_cmp = 0;
    n_bad = 0;
    bus8.in_valid = 1'b0; bus8.A = 8'h00; bus8.B = 8'h00; bus8.sel = 3'b000; bus8.out_ready = 1'b0;
    bus4.in_valid = 1'b0; bus4.A = 4'h0;  bus4.B = 4'h0;  bus4.sel = 3'b000; bus4.out_ready = 1'b0;

    vecs.push_back('{"add_wrap",   3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{"add_ovf",    3'b000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1});
    vecs.push_back('{"sub_ovf",    3'b001, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1});
    vecs.push_back('{"sub_borrow", 3'b001, 8'h01, 8'h02, 8'hFF, 1'b1, 1'b0});
    vecs.push_back('{"and",        3'b010, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0});
    vecs.push_back('{"or",         3'b011, 8'hF0, 8'h0C, 8'hFC, 1'b0, 1'b0});
    vecs.push_back('{"not",        3'b100, 8'h5A, 8'hFF, 8'hA5, 1'b0, 1'b0});
    vecs.push_back('{"xor",        3'b101, 8'h3C, 8'h0F, 8'h33, 1'b0, 1'b0});
    vecs.push_back('{"reserved",   3'b111, 8'h12, 8'h34, 8'h00, 1'b0, 1'b0});
`ifndef ALU_SEQ_MUL_EN
    vecs.push_back('{"mul_off",    3'b110, 8'h10, 8'h11, 8'h00, 1'b0, 1'b0});
`endif

    // Reset state, checked while reset is held and after release.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset8("rst_hold");
    check("rst4_out_valid", 32'(bus4.out_valid), 32'd0);
    check("rst4_zero",      32'(bus4.zero),      32'd1);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(bus8.in_ready), 32'd1);
    check_reset8("rst_rel");

    // Single-cycle opcode table with the consumer always ready.
    bus8.out_ready = 1'b1;
    foreach (vecs[i]) begin
      check({vecs[i].tag, "_in_ready_pre"}, 32'(bus8.in_ready), 32'd1);
      issue8(vecs[i].sel, vecs[i].a, vecs[i].b, lat);
      check({vecs[i].tag, "_latency"}, 32'(lat),           32'd1);
      check({vecs[i].tag, "_result"},  32'(bus8.result),   32'(vecs[i].res));
      check({vecs[i].tag, "_carry"},   32'(bus8.carry),    32'(vecs[i].c));
      check({vecs[i].tag, "_ovf"},     32'(bus8.ovf),      32'(vecs[i].o));
      check({vecs[i].tag, "_zero"},    32'(bus8.zero),     32'(vecs[i].res == 8'h00));
      check({vecs[i].tag, "_neg"},     32'(bus8.neg),      32'(vecs[i].res[7]));
      check({vecs[i].tag, "_in_ready_busy"}, 32'(bus8.in_ready), 32'd0);
      @(posedge clk); #1;
      check({vecs[i].tag, "_retired"},  32'(bus8.out_valid), 32'd0);
      check({vecs[i].tag, "_in_ready"}, 32'(bus8.in_ready),  32'd1);
    end

    // XOR held under backpressure for five cycles, then retired.
    bus8.out_ready = 1'b0;
    issue8(3'b101, 8'hAA, 8'hFF, lat);
    check("xor_hold_latency", 32'(lat), 32'd1);
    check("xor_hold_result",  32'(bus8.result), 32'h55);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("xor_hold_stable", 32'(bus8.result),    32'h55);
      check("xor_hold_valid",  32'(bus8.out_valid), 32'd1);
      check("xor_hold_busy",   32'(bus8.in_ready),  32'd0);
    end
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
    check("xor_retire_valid", 32'(bus8.out_valid), 32'd0);
    check("xor_retire_ready", 32'(bus8.in_ready),  32'd1);

    // Multiply: 0x10*0x11 = 0x110, and 0x0D*0x0B = 0x8F.
    issue8(3'b110, 8'h10, 8'h11, lat);
`ifdef ALU_SEQ_MUL_EN
    check("mul_latency", 32'(lat),         32'd9);
    check("mul_result",  32'(bus8.result), 32'h10);
    check("mul_carry",   32'(bus8.carry),  32'd1);
    check("mul_zero",    32'(bus8.zero),   32'd0);
`else
    check("mul_latency", 32'(lat),         32'd1);
    check("mul_result",  32'(bus8.result), 32'h00);
    check("mul_carry",   32'(bus8.carry),  32'd0);
    check("mul_zero",    32'(bus8.zero),   32'd1);
`endif
    check("mul_ovf", 32'(bus8.ovf), 32'd0);
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
    check("mul_retire", 32'(bus8.out_valid), 32'd0);

    issue8(3'b110, 8'h0D, 8'h0B, lat);
`ifdef ALU_SEQ_MUL_EN
    check("mul2_latency", 32'(lat),         32'd9);
    check("mul2_result",  32'(bus8.result), 32'h8F);
    check("mul2_carry",   32'(bus8.carry),  32'd0);
    check("mul2_neg",     32'(bus8.neg),    32'd1);
`else
    check("mul2_latency", 32'(lat),         32'd1);
    check("mul2_result",  32'(bus8.result), 32'h00);
`endif
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;

    // Reset pulsed while a multiply of 0x0F*0x0F is in progress.
    bus8.sel = 3'b110; bus8.A = 8'h0F; bus8.B = 8'h0F; bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    check("abort_busy", 32'(bus8.in_ready), 32'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset8("abort_in_rst");
    #9 rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (bus8.out_valid === 1'b1) seen = 1'b1;
    end
    check("abort_no_result", 32'(seen), 32'd0);
    check("abort_in_ready",  32'(bus8.in_ready), 32'd1);
    check_reset8("abort_after");

    // WIDTH=4: 0x7 + 0x1 overflows into the sign bit.
    bus4.sel = 3'b000; bus4.A = 4'h7; bus4.B = 4'h1; bus4.in_valid = 1'b1;
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    check("w4_valid",  32'(bus4.out_valid), 32'd1);
    check("w4_result", 32'(bus4.result),    32'h8);
    check("w4_ovf",    32'(bus4.ovf),       32'd1);
    check("w4_neg",    32'(bus4.neg),       32'd1);
    check("w4_carry",  32'(bus4.carry),     32'd0);
    check("w4_zero",   32'(bus4.zero),      32'd0);
    bus4.out_ready = 1'b1;
    @(posedge clk); #1;
    bus4.out_ready = 1'b0;
    check("w4_retire", 32'(bus4.out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
